// File: rtl/ps2_mouse_pkg.sv
// Shared constants and types for the PS/2 mouse front end: frame layout,
// packet size, byte-0 field positions and the receiver state encoding.
package ps2_mouse_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = PS2_FRAME_BITS - 3;  // minus start, parity, stop
    localparam int PKT_BYTES      = 3;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchroniser, hysteresis glitch filter
// on the clock line, start/data/parity/stop FSM and a mid-frame idle timeout.
module ps2_rx_frame
    import ps2_mouse_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50350
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]            clk_sync_q;
    logic [1:0]            data_sync_q;
    logic [FILTER_LEN-1:0] hist_q;
    logic                  filt_q;
    logic                  filt_d;
    logic                  all_low;
    logic                  all_high;
    logic                  sample_evt;
    logic                  sdata;

    rx_state_e             state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic                  byte_valid_q, byte_valid_d;
    logic [7:0]            byte_data_q, byte_data_d;
    logic                  frame_err_q, frame_err_d;

    assign all_low    = ~|hist_q;
    assign all_high   = &hist_q;
    assign filt_d     = all_low ? 1'b0 : (all_high ? 1'b1 : filt_q);
    assign sample_evt = filt_q & all_low;
    assign sdata      = data_sync_q[1];

    // NOTE: synchroniser and filter history reset to 1 (idle bus) so reset
    // release can never look like a falling PS/2 clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            hist_q      <= '1;
            filt_q      <= 1'b1;
        end else begin
            // NOTE: sequential state uses <= so every flop sees pre-edge values.
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            hist_q      <= {hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
            filt_q      <= filt_d;
        end
    end

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path infers a latch.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        to_cnt_d     = to_cnt_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (sample_evt && !sdata) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (sample_evt) begin
                    shift_d = {sdata, shift_q[7:1]};
                    if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
                    else bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            PARITY: begin
                if (sample_evt) begin
                    parity_d = sdata;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (sample_evt) begin
                    state_d = IDLE;
                    if ((^shift_q ^ parity_q) && sdata) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Idle counter only runs inside a frame; expiry abandons the frame.
        if (state_q != IDLE) begin
            if (sample_evt) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d     = IDLE;
                frame_err_d = 1'b1;
                to_cnt_d    = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            to_cnt_q     <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            to_cnt_q     <= to_cnt_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = byte_data_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse front end: assembles 3-byte packets from received frames and
// keeps a clamped absolute cursor position plus current button state.
module ps2_mouse_tracker
    import ps2_mouse_pkg::*;
#(
    parameter int COORD_W        = 10,
    parameter int X_MAX          = 632,
    parameter int Y_MAX          = 472,
    parameter int X_INIT         = 320,
    parameter int Y_INIT         = 240,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50350,
    parameter int Y_INVERT       = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ps2_clk_i,
    input  logic               ps2_data_i,
    input  logic               recenter,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [2:0]         btn,
    output logic               pkt_valid,
    output logic               byte_valid,
    output logic [7:0]         byte_data,
    output logic               frame_err
);

    localparam int SW = COORD_W + 2;
    localparam logic signed [SW-1:0] X_MAX_S = SW'(X_MAX);
    localparam logic signed [SW-1:0] Y_MAX_S = SW'(Y_MAX);

    logic [1:0]               idx_q, idx_d;
    logic [7:0]               b0_q, b0_d;
    logic [7:0]               b1_q, b1_d;
    logic [COORD_W-1:0]       pos_x_q, pos_x_d;
    logic [COORD_W-1:0]       pos_y_q, pos_y_d;
    logic [2:0]               btn_q, btn_d;
    logic                     pkt_valid_q, pkt_valid_d;

    logic [8:0]               dx9, dy9;
    logic signed [SW-1:0]     dx_s, dy_s, sum_x, sum_y;
    logic [COORD_W-1:0]       new_x, new_y;

    ps2_rx_frame #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2_clk_i    (ps2_clk_i),
        .ps2_data_i   (ps2_data_i),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data),
        .frame_err_o  (frame_err)
    );

    // Deltas use the byte currently on byte_data as byte 2; overflow zeroes the axis.
    always_comb begin
        dx9   = b0_q[XOVF] ? 9'd0 : {b0_q[XSIGN], b1_q};
        dy9   = b0_q[YOVF] ? 9'd0 : {b0_q[YSIGN], byte_data};
        dx_s  = {{(SW-9){dx9[8]}}, dx9};
        dy_s  = {{(SW-9){dy9[8]}}, dy9};
        sum_x = $signed({2'b00, pos_x_q}) + dx_s;
        if (Y_INVERT != 0) sum_y = $signed({2'b00, pos_y_q}) - dy_s;
        else               sum_y = $signed({2'b00, pos_y_q}) + dy_s;

        if (sum_x < 0)             new_x = '0;
        else if (sum_x > X_MAX_S)  new_x = COORD_W'(X_MAX);
        else                       new_x = sum_x[COORD_W-1:0];

        if (sum_y < 0)             new_y = '0;
        else if (sum_y > Y_MAX_S)  new_y = COORD_W'(Y_MAX);
        else                       new_y = sum_y[COORD_W-1:0];
    end

    always_comb begin
        idx_d       = idx_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        btn_d       = btn_q;
        pkt_valid_d = 1'b0;

        if (frame_err) begin
            idx_d = '0;
            b0_d  = '0;
            b1_d  = '0;
        end else if (byte_valid) begin
            case (idx_q)
                2'd0: begin
                    // Byte 0 must carry the always-one sync bit, else resync.
                    if (byte_data[SYNC]) begin
                        b0_d  = byte_data;
                        idx_d = 2'd1;
                    end
                end
                2'd1: begin
                    b1_d  = byte_data;
                    idx_d = 2'(PKT_BYTES - 1);
                end
                default: begin
                    idx_d = '0;
                    if (b0_q[SYNC]) begin
                        pkt_valid_d = 1'b1;
                        btn_d       = b0_q[BTN_M:BTN_L];
                        pos_x_d     = new_x;
                        pos_y_d     = new_y;
                    end
                end
            endcase
        end

        if (recenter) begin
            pos_x_d = COORD_W'(X_INIT);
            pos_y_d = COORD_W'(Y_INIT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            pos_x_q     <= COORD_W'(X_INIT);
            pos_y_q     <= COORD_W'(Y_INIT);
            btn_q       <= '0;
            pkt_valid_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            btn_q       <= btn_d;
            pkt_valid_q <= pkt_valid_d;
        end
    end

    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign btn       = btn_q;
    assign pkt_valid = pkt_valid_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Self-checking bench for ps2_mouse_tracker: drives PS/2 frames bit by bit and
// compares outputs with an integer-arithmetic packet/cursor model.
module tb_ps2_mouse_tracker;

    localparam int COORD_W = 10;
    localparam int X_MAX   = 632;
    localparam int Y_MAX   = 472;
    localparam int X_INIT  = 320;
    localparam int Y_INIT  = 240;
    localparam int TIMEOUT = 1000;
    localparam int HALF    = 20;
    localparam int GAP     = 40;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ps2_clk_i = 1'b1;
    logic               ps2_data_i = 1'b1;
    logic               recenter = 1'b0;
    logic [COORD_W-1:0] pos_x, pos_y;
    logic [2:0]         btn;
    logic               pkt_valid, byte_valid, frame_err;
    logic [7:0]         byte_data;

    always #5 clk = ~clk;

    ps2_mouse_tracker #(
        .COORD_W        (COORD_W),
        .X_MAX          (X_MAX),
        .Y_MAX          (Y_MAX),
        .X_INIT         (X_INIT),
        .Y_INIT         (Y_INIT),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (TIMEOUT),
        .Y_INVERT       (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .recenter   (recenter),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .btn        (btn),
        .pkt_valid  (pkt_valid),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    int checks = 0;
    int errors = 0;

    // Pulse counters observed from the DUT
    int         n_bv = 0, n_pkt = 0, n_err = 0;
    logic [7:0] last_byte = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_valid) begin
                n_bv++;
                last_byte = byte_data;
            end
            if (pkt_valid) n_pkt++;
            if (frame_err) n_err++;
        end
    end

    // Reference model
    int         mx = X_INIT, my = Y_INIT;
    logic [2:0] mbtn = 3'b000;
    logic [7:0] mq[$];
    int         m_bv = 0, m_pkt = 0, m_err = 0;
    logic [7:0] m_last = 8'h00;

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int dx, dy;
        m_bv++;
        m_last = b;
        if (mq.size() == 0 && !b[3]) return;
        mq.push_back(b);
        if (mq.size() == 3) begin
            dx = mq[0][4] ? int'(mq[1]) - 256 : int'(mq[1]);
            dy = mq[0][5] ? int'(mq[2]) - 256 : int'(mq[2]);
            if (mq[0][6]) dx = 0;
            if (mq[0][7]) dy = 0;
            mx   = clampi(mx + dx, X_MAX);
            my   = clampi(my - dy, Y_MAX);
            mbtn = mq[0][2:0];
            m_pkt++;
            mq.delete();
        end
    endfunction

    function automatic void model_err();
        m_err++;
        mq.delete();
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " pos_x"},      32'(pos_x),     32'(mx));
        check({tag, " pos_y"},      32'(pos_y),     32'(my));
        check({tag, " btn"},        32'(btn),       32'(mbtn));
        check({tag, " pkt_cnt"},    32'(n_pkt),     32'(m_pkt));
        check({tag, " byte_cnt"},   32'(n_bv),      32'(m_bv));
        check({tag, " err_cnt"},    32'(n_err),     32'(m_err));
        check({tag, " last_byte"},  32'(last_byte), 32'(m_last));
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data_i = b;
        repeat (HALF) @(posedge clk);
        ps2_clk_i = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk_i = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        ps2_data_i = 1'b1;
        repeat (GAP) @(posedge clk);
        if (bad_par) model_err();
        else         model_byte(b);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_frame(b0, 1'b0);
        send_frame(b1, 1'b0);
        send_frame(b2, 1'b0);
    endtask

    task automatic pulse_recenter();
        @(negedge clk);
        recenter = 1'b1;
        @(negedge clk);
        recenter = 1'b0;
        mx = X_INIT;
        my = Y_INIT;
    endtask

    initial begin
        logic [7:0] rb[3];
        int         bad_idx;
        int         x_before;

        repeat (5) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("reset pos_x",      32'(pos_x),      32'(X_INIT));
        check("reset pos_y",      32'(pos_y),      32'(Y_INIT));
        check("reset btn",        32'(btn),        32'd0);
        check("reset pkt_valid",  32'(pkt_valid),  32'd0);
        check("reset byte_valid", 32'(byte_valid), 32'd0);
        check("reset byte_data",  32'(byte_data),  32'd0);
        check("reset frame_err",  32'(frame_err),  32'd0);

        // Basic packet
        send_pkt(8'h08, 8'h05, 8'h03);
        check_all("basic");
        check("basic x const", 32'(pos_x), 32'd325);
        check("basic y const", 32'(pos_y), 32'd237);
        check("basic pkts",    32'(n_pkt), 32'd1);
        check("basic bytes",   32'(n_bv),  32'd3);

        // Negative deltas with Y inversion
        pulse_recenter();
        send_pkt(8'h38, 8'hF6, 8'hFB);
        check_all("negdelta");
        check("negdelta x const", 32'(pos_x), 32'd310);
        check("negdelta y const", 32'(pos_y), 32'd245);

        // Clamp at zero
        pulse_recenter();
        send_pkt(8'h18, 8'h01, 8'hEB);
        send_pkt(8'h18, 8'hC4, 8'h00);
        check("to 5,5 x", 32'(pos_x), 32'd5);
        check("to 5,5 y", 32'(pos_y), 32'd5);
        send_pkt(8'h18, 8'hEC, 8'h00);
        check_all("clamp low");
        check("clamp low const", 32'(pos_x), 32'd0);

        // Clamp at X_MAX
        pulse_recenter();
        send_pkt(8'h08, 8'hFF, 8'h00);
        send_pkt(8'h08, 8'h37, 8'h00);
        check("to 630", 32'(pos_x), 32'd630);
        send_pkt(8'h08, 8'h0A, 8'h00);
        check_all("clamp high");
        check("clamp high const", 32'(pos_x), 32'd632);

        // X overflow ignores dx
        send_pkt(8'h48, 8'h50, 8'h00);
        check_all("xovf");
        check("xovf const", 32'(pos_x), 32'd632);

        // Parity error on byte 1
        pulse_recenter();
        send_frame(8'h08, 1'b0);
        send_frame(8'h05, 1'b1);
        check_all("parity err");
        send_pkt(8'h09, 8'h01, 8'h01);
        check_all("after parity");
        check("after parity x", 32'(pos_x), 32'd321);
        check("after parity y", 32'(pos_y), 32'd239);
        check("after parity btn", 32'(btn), 32'd1);

        // Timeout mid-frame
        x_before = int'(pos_x);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_data_i = 1'b1;
        repeat (TIMEOUT + 200) @(posedge clk);
        model_err();
        check_all("timeout");
        repeat (TIMEOUT + 200) @(posedge clk);
        check("timeout once", 32'(n_err), 32'(m_err));
        send_frame(8'h00, 1'b0);
        send_pkt(8'h08, 8'h02, 8'h00);
        check_all("after timeout");
        check("after timeout x+2", 32'(pos_x), 32'(x_before + 2));

        // Recenter coinciding with the packet update
        send_frame(8'h0A, 1'b0);
        send_frame(8'h10, 1'b0);
        fork
            send_frame(8'h10, 1'b0);
            begin : watch
                logic found;
                found = 1'b0;
                for (int i = 0; i < 3000; i++) begin
                    @(negedge clk);
                    if (byte_valid) begin
                        found = 1'b1;
                        break;
                    end
                end
                recenter = 1'b1;
                @(negedge clk);
                check("rc pkt_valid", 32'(pkt_valid), 32'd1);
                recenter = 1'b0;
                check("rc window", 32'(found), 32'd1);
            end
        join
        mx = X_INIT;
        my = Y_INIT;
        check_all("recenter sim");
        check("recenter sim btn", 32'(btn), 32'd2);

        // Short glitch on the PS/2 clock with data low
        @(posedge clk);
        ps2_data_i = 1'b0;
        #9 ps2_clk_i = 1'b0;
        #2 ps2_clk_i = 1'b1;
        repeat (TIMEOUT + 200) @(posedge clk);
        ps2_data_i = 1'b1;
        repeat (GAP) @(posedge clk);
        check_all("glitch");
        send_pkt(8'h08, 8'h04, 8'h04);
        check_all("after glitch");

        // Asynchronous reset mid-packet and mid-frame
        send_frame(8'h08, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        #3 rst_n = 1'b0;
        ps2_clk_i  = 1'b1;
        ps2_data_i = 1'b1;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b1;
        mx = X_INIT;
        my = Y_INIT;
        mbtn = 3'b000;
        mq.delete();
        repeat (50) @(posedge clk);
        check_all("async reset");
        check("async reset byte_data", 32'(byte_data), 32'd0);
        send_pkt(8'h08, 8'h03, 8'h04);
        check_all("after async reset");

        // Randomised packets, occasional bad parity and recenter
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 3) == 0) pulse_recenter();
            rb[0] = 8'($urandom);
            rb[0][3] = 1'b1;
            if ($urandom_range(0, 3) != 0) rb[0][7:6] = 2'b00;
            rb[1] = 8'($urandom);
            rb[2] = 8'($urandom);
            bad_idx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            for (int j = 0; j < 3; j++) send_frame(rb[j], bad_idx == j + 1);
            check_all("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
